// File: rtl/ptw_mem_arb.sv
// Page-table-walk memory arbiter: round-robin between IFU (I) and LSU (D) PTE reads onto one bus.
// Optional bus-response timeout in WAIT is enabled with `define PTW_ARB_TIMEOUT_EN.
module ptw_mem_arb #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_mem_req_i,
  input  logic [AW-1:0] i_mem_addr_i,
  output logic [DW-1:0] i_mem_rdata_o,
  output logic          i_mem_rvalid_o,
  output logic          i_mem_err_o,
  input  logic          i_flush_i,
  input  logic          d_mem_req_i,
  input  logic [AW-1:0] d_mem_addr_i,
  output logic [DW-1:0] d_mem_rdata_o,
  output logic          d_mem_rvalid_o,
  output logic          d_mem_err_o,
  input  logic          d_flush_i,
  output logic          bus_req_o,
  output logic [AW-1:0] bus_addr_o,
  input  logic          bus_ready_i,
  input  logic          bus_rvalid_i,
  input  logic [DW-1:0] bus_rdata_i,
  input  logic          bus_err_i
);

  // Handshakes: a port holds req (and addr) until its one-cycle rvalid; the bus
  // accepts bus_req_o in a cycle with bus_ready_i and answers later with one bus_rvalid_i.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_e        state_q;
  logic          owner_q;
  logic          last_grant_q;
  logic          discard_q;
  logic          mask_i_q;
  logic          mask_d_q;
  logic          bus_req_q;
  logic [AW-1:0] bus_addr_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_rvalid_q;
  logic          d_rvalid_q;
  logic          i_err_q;
  logic          d_err_q;

  logic          elig_i;
  logic          elig_d;
  logic          grant_any;
  logic          grant_port;
  logic          owner_flush;
  logic [AW-1:0] sel_addr;

`ifdef PTW_ARB_TIMEOUT_EN
  logic [15:0]   wait_cnt_q;
`else
  logic          unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    elig_i      = i_mem_req_i & ~i_flush_i & ~mask_i_q;
    elig_d      = d_mem_req_i & ~d_flush_i & ~mask_d_q;
    grant_any   = elig_i | elig_d;
    grant_port  = PORT_I;
    if (elig_i && elig_d) begin
      grant_port = ~last_grant_q;
    end else if (elig_d) begin
      grant_port = PORT_D;
    end
    sel_addr    = (grant_port == PORT_D) ? d_mem_addr_i : i_mem_addr_i;
    owner_flush = (owner_q == PORT_D) ? d_flush_i : i_flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_D;
      discard_q    <= 1'b0;
      mask_i_q     <= 1'b0;
      mask_d_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          mask_i_q <= 1'b0;
          mask_d_q <= 1'b0;
          if (grant_any) begin
            owner_q    <= grant_port;
            bus_addr_q <= sel_addr & ~AW'(3);
            bus_req_q  <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus_ready_i) begin
            bus_req_q    <= 1'b0;
            last_grant_q <= owner_q;
            discard_q    <= owner_flush;
            state_q      <= S_WAIT;
`ifdef PTW_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
          end else if (owner_flush) begin
            bus_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus_rvalid_i) begin
            if (discard_q || owner_flush) begin
              discard_q <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              // An errored PTE never exposes bus data to the walker.
              if (owner_q == PORT_D) begin
                d_rvalid_q <= 1'b1;
                d_err_q    <= bus_err_i;
                d_rdata_q  <= bus_err_i ? '0 : bus_rdata_i;
              end else begin
                i_rvalid_q <= 1'b1;
                i_err_q    <= bus_err_i;
                i_rdata_q  <= bus_err_i ? '0 : bus_rdata_i;
              end
              state_q <= S_RESP;
            end
`ifdef PTW_ARB_TIMEOUT_EN
          end else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            if (discard_q || owner_flush) begin
              discard_q <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              if (owner_q == PORT_D) begin
                d_rvalid_q <= 1'b1;
                d_err_q    <= 1'b1;
                d_rdata_q  <= '0;
              end else begin
                i_rvalid_q <= 1'b1;
                i_err_q    <= 1'b1;
                i_rdata_q  <= '0;
              end
              state_q <= S_RESP;
            end
`endif
          end else begin
            if (owner_flush) begin
              discard_q <= 1'b1;
            end
`ifdef PTW_ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
          end
        end
        S_RESP: begin
          // Mask the owner for one IDLE cycle so a late-dropping req is not re-served.
          i_rvalid_q <= 1'b0;
          d_rvalid_q <= 1'b0;
          i_err_q    <= 1'b0;
          d_err_q    <= 1'b0;
          discard_q  <= 1'b0;
          if (owner_q == PORT_D) begin
            mask_d_q <= 1'b1;
          end else begin
            mask_i_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_req_o      = bus_req_q;
  assign bus_addr_o     = bus_addr_q;
  assign i_mem_rdata_o  = i_rdata_q;
  assign i_mem_rvalid_o = i_rvalid_q;
  assign i_mem_err_o    = i_err_q;
  assign d_mem_rdata_o  = d_rdata_q;
  assign d_mem_rvalid_o = d_rvalid_q;
  assign d_mem_err_o    = d_err_q;

endmodule

// File: tb/tb_ptw_mem_arb.sv
// Directed bench for ptw_mem_arb (default build): latency, round-robin, mask, flush, error, reset.
module tb_ptw_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          i_mem_req_i;
  logic [AW-1:0] i_mem_addr_i;
  logic [DW-1:0] i_mem_rdata_o;
  logic          i_mem_rvalid_o;
  logic          i_mem_err_o;
  logic          i_flush_i;
  logic          d_mem_req_i;
  logic [AW-1:0] d_mem_addr_i;
  logic [DW-1:0] d_mem_rdata_o;
  logic          d_mem_rvalid_o;
  logic          d_mem_err_o;
  logic          d_flush_i;
  logic          bus_req_o;
  logic [AW-1:0] bus_addr_o;
  logic          bus_ready_i;
  logic          bus_rvalid_i;
  logic [DW-1:0] bus_rdata_i;
  logic          bus_err_i;

  int n_checks = 0;
  int n_errors = 0;
  int i_rv_cnt = 0;
  int d_rv_cnt = 0;

  // Scoreboard entries: {port, rdata}
  logic [DW:0] exp_q[$];

  ptw_mem_arb #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .i_mem_req_i(i_mem_req_i), .i_mem_addr_i(i_mem_addr_i),
    .i_mem_rdata_o(i_mem_rdata_o), .i_mem_rvalid_o(i_mem_rvalid_o),
    .i_mem_err_o(i_mem_err_o), .i_flush_i(i_flush_i),
    .d_mem_req_i(d_mem_req_i), .d_mem_addr_i(d_mem_addr_i),
    .d_mem_rdata_o(d_mem_rdata_o), .d_mem_rvalid_o(d_mem_rvalid_o),
    .d_mem_err_o(d_mem_err_o), .d_flush_i(d_flush_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
    .bus_ready_i(bus_ready_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (i_mem_rvalid_o) i_rv_cnt++;
      if (d_mem_rvalid_o) d_rv_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    i_mem_req_i  = 1'b0;
    i_mem_addr_i = '0;
    i_flush_i    = 1'b0;
    d_mem_req_i  = 1'b0;
    d_mem_addr_i = '0;
    d_flush_i    = 1'b0;
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    bus_err_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Bus driver: wait for the request, accept at once, return data next cycle.
  // Returns in the RESP cycle (response outputs visible).
  task automatic do_bus(input logic [AW-1:0] exp_addr, input logic [DW-1:0] data, input logic err);
    for (int n = 0; n < 20 && !bus_req_o; n++) tick();
    check("bus_req_seen", bus_req_o, 1);
    check("bus_addr", bus_addr_o, exp_addr);
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = data;
    bus_err_i    = err;
    tick();
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
  endtask

  initial begin
    logic [DW:0] e;
    int          i0;
    int          d0;
    logic [1:0]  st;

    do_reset();

    // Reset state
    check("rst_bus_req", bus_req_o, 0);
    check("rst_bus_addr", bus_addr_o, 0);
    check("rst_i_out", {i_mem_rvalid_o, i_mem_err_o, i_mem_rdata_o}, 0);
    check("rst_d_out", {d_mem_rvalid_o, d_mem_err_o, d_mem_rdata_o}, 0);
    st = dut.state_q;
    check("rst_state", st, 0);

    // Minimum latency on port I, plus mask against a one-cycle-late req drop
    i_mem_req_i  = 1'b1;
    i_mem_addr_i = 32'h8000_1003;
    check("c0_bus_req", bus_req_o, 0);
    tick();
    check("c1_bus_req", bus_req_o, 1);
    check("c1_bus_addr", bus_addr_o, 32'h8000_1000);
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i  = 1'b0;
    check("c2_bus_req_drop", bus_req_o, 0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h2000_00CF;
    tick();
    bus_rvalid_i = 1'b0;
    check("c3_i_rvalid", i_mem_rvalid_o, 1);
    check("c3_i_rdata", i_mem_rdata_o, 32'h2000_00CF);
    check("c3_i_err", i_mem_err_o, 0);
    check("c3_d_out", {d_mem_rvalid_o, d_mem_err_o, d_mem_rdata_o}, 0);
    tick();
    check("c4_i_rvalid", i_mem_rvalid_o, 0);
    check("c4_i_rdata_hold", i_mem_rdata_o, 32'h2000_00CF);
    i_mem_req_i = 1'b0;
    tick();
    check("c5_mask_no_regrant", bus_req_o, 0);

    // Stray bus_rvalid in IDLE is ignored
    i0 = i_rv_cnt;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD_BEEF;
    tick();
    bus_rvalid_i = 1'b0;
    tick();
    check("stray_rvalid_i", i_rv_cnt - i0, 0);
    check("stray_rdata_hold", i_mem_rdata_o, 32'h2000_00CF);

    // Round-robin with both requesting from reset: I, D, I, D
    do_reset();
    i0 = i_rv_cnt;
    d0 = d_rv_cnt;
    i_mem_req_i  = 1'b1;
    i_mem_addr_i = 32'h0000_1107;
    d_mem_req_i  = 1'b1;
    d_mem_addr_i = 32'h0000_2206;
    for (int k = 0; k < 4; k++) begin
      logic p;
      p = k[0];
      exp_q.push_back({p, 32'hA000_0000 + 32'(k)});
      do_bus(p ? 32'h0000_2204 : 32'h0000_1104, 32'hA000_0000 + 32'(k), 1'b0);
      if (k == 3) begin
        i_mem_req_i = 1'b0;
        d_mem_req_i = 1'b0;
      end
      e = exp_q.pop_front();
      check("rr_i_rvalid", i_mem_rvalid_o, !e[DW]);
      check("rr_d_rvalid", d_mem_rvalid_o, e[DW]);
      check("rr_rdata", e[DW] ? d_mem_rdata_o : i_mem_rdata_o, e[DW-1:0]);
    end
    repeat (4) tick();
    check("rr_i_count", i_rv_cnt - i0, 2);
    check("rr_d_count", d_rv_cnt - d0, 2);
    check("rr_idle_after", bus_req_o, 0);

    // D flush while the request is still unaccepted
    d0 = d_rv_cnt;
    d_mem_req_i  = 1'b1;
    d_mem_addr_i = 32'h0000_3000;
    tick();
    check("fl_issue_req", bus_req_o, 1);
    tick();
    d_flush_i   = 1'b1;
    d_mem_req_i = 1'b0;
    tick();
    d_flush_i = 1'b0;
    check("fl_bus_req_drop", bus_req_o, 0);
    st = dut.state_q;
    check("fl_state_idle", st, 0);
    repeat (3) tick();
    check("fl_no_d_rvalid", d_rv_cnt - d0, 0);

    // I flush in WAIT discards the late data; D is then served normally
    i0 = i_rv_cnt;
    i_mem_req_i  = 1'b1;
    i_mem_addr_i = 32'h0000_4000;
    for (int n = 0; n < 20 && !bus_req_o; n++) tick();
    check("wf_bus_req", bus_req_o, 1);
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i = 1'b0;
    i_flush_i   = 1'b1;
    i_mem_req_i = 1'b0;
    tick();
    i_flush_i = 1'b0;
    tick();
    tick();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h0BAD_0BAD;
    tick();
    bus_rvalid_i = 1'b0;
    check("wf_no_i_rvalid", i_mem_rvalid_o, 0);
    d_mem_req_i  = 1'b1;
    d_mem_addr_i = 32'h0000_5004;
    do_bus(32'h0000_5004, 32'h3000_00C1, 1'b0);
    d_mem_req_i = 1'b0;
    check("wf_d_rvalid", d_mem_rvalid_o, 1);
    check("wf_d_rdata", d_mem_rdata_o, 32'h3000_00C1);
    check("wf_i_count", i_rv_cnt - i0, 0);
    tick();

    // Bus error on D forces rdata to zero
    d_mem_req_i  = 1'b1;
    d_mem_addr_i = 32'h0000_6008;
    do_bus(32'h0000_6008, 32'hFFFF_FFFF, 1'b1);
    d_mem_req_i = 1'b0;
    check("err_d_rvalid", d_mem_rvalid_o, 1);
    check("err_d_err", d_mem_err_o, 1);
    check("err_d_rdata", d_mem_rdata_o, 0);
    check("err_i_out", {i_mem_rvalid_o, i_mem_err_o}, 0);
    tick();
    check("err_pulse_end", {d_mem_rvalid_o, d_mem_err_o}, 0);

    // Asynchronous reset in the RESP cycle clears outputs immediately
    i_mem_req_i  = 1'b1;
    i_mem_addr_i = 32'h0000_7000;
    do_bus(32'h0000_7000, 32'h1234_5678, 1'b0);
    check("ar_pre_rvalid", i_mem_rvalid_o, 1);
    rst = 1'b1;
    #1;
    check("ar_i_out", {i_mem_rvalid_o, i_mem_err_o, i_mem_rdata_o}, 0);
    st = dut.state_q;
    check("ar_state", st, 0);
    i_mem_req_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
